// File: rtl/npc_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, AXI response code and the canonical NOP.
package npc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    OUT  = 2'd3
  } ifu_state_t;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;

  // RV32 without compressed instructions needs word-aligned fetch addresses.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_watchdog.sv
// R-channel wait watchdog: counts DATA cycles and flags expiry on the LIMIT-th cycle.
// Only compiled when IFU_TIMEOUT_EN is defined; single cycle, no backpressure.
`ifdef IFU_TIMEOUT_EN
module ifu_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // Count already holds LIMIT-1 on the LIMIT-th wait cycle, so expiry is flagged then.
  assign expired = enable && (count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/ifu_fetch.sv
// Fetch stage: one AXI4-Lite read per request, 3-cycle minimum latency, one transaction in flight.
// Backpressure: req_ready low while the bus is busy; result held until inst_ready. IFU_TIMEOUT_EN adds an R-wait watchdog.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_snpc,
  output logic              inst_fault
);

  ifu_state_t state;
  logic       accept;
  logic       misaligned;
  logic       wd_expired;

  // OUT chains straight into the next fetch when decode drains in the same cycle.
  assign req_ready  = !rst && ((state == IDLE) || ((state == OUT) && inst_ready));
  assign accept     = req_valid && req_ready;
  assign misaligned = pc_misaligned(req_pc[1:0]);

  // The latched PC doubles as the bus address.
  assign araddr = inst_pc;

`ifdef IFU_TIMEOUT_EN
  ifu_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .enable  (state == DATA),
    .clear   (arvalid && arready),
    .expired (wd_expired)
  );
`else
  // Without the watchdog DATA waits indefinitely for rvalid.
  assign wd_expired = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst_fault <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_snpc  <= '0;
    end else if (accept) begin
      inst_pc   <= req_pc;
      inst_snpc <= req_pc + ADDR_W'(4);
      if (misaligned) begin
        state      <= OUT;
        inst_valid <= 1'b1;
        inst_fault <= 1'b1;
        inst       <= DATA_W'(INST_NOP);
      end else begin
        state      <= ADDR;
        inst_valid <= 1'b0;
        arvalid    <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (rvalid) begin
            rready     <= 1'b0;
            inst       <= rdata;
            inst_fault <= (rresp != AXI_RESP_OKAY);
            inst_valid <= 1'b1;
            state      <= OUT;
          end else if (wd_expired) begin
            rready     <= 1'b0;
            inst       <= DATA_W'(INST_NOP);
            inst_fault <= 1'b1;
            inst_valid <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed timing scenarios, then randomized traffic against a memory model and scoreboard.
module tb_ifu_fetch;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_pc, araddr, rdata, inst, inst_pc, inst_snpc;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp;
  logic        inst_valid, inst_ready, inst_fault;

  ifu_fetch #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_snpc(inst_snpc), .inst_fault(inst_fault)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   rand_mode = 0;
  bit   slave_en  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Reference behaviour: what decode must see for a fetch of pc answered with (w, r).
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] w, input logic [1:0] r);
    exp_t e;
    e.pc   = pc;
    e.snpc = pc + 32'd4;
    if (pc % 4 != 0) begin
      e.inst  = 32'h0000_0013;
      e.fault = 1'b1;
    end else begin
      e.inst  = w;
      e.fault = (r != 2'b00);
    end
    return e;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hA5A5_0000) * 32'h0001_9660 + 32'h3C6E_F35F;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h2545_F491;
    if (h[31:29] == 3'd0) return 2'b10;
    if (h[31:29] == 3'd1) return 2'b11;
    return 2'b00;
  endfunction

  task automatic send_req(input logic [31:0] pc);
    bit done = 0;
    req_valid = 1'b1;
    req_pc    = pc;
    for (int i = 0; i < 200 && !done; i++) begin
      smp();
      if (req_ready) begin
        exp_q.push_back(model(pc, mem_word(pc), mem_resp(pc)));
        done = 1;
      end
      tick();
    end
    req_valid = 1'b0;
    check("req_accept", done, 1'b1);
  endtask

  // Scoreboard monitor plus handshake-stability rules.
  initial begin : monitor
    exp_t        e;
    logic        prev_hold, prev_ar;
    logic [96:0] prev_bus;
    logic [31:0] prev_araddr;
    prev_hold = 0; prev_ar = 0; prev_bus = '0; prev_araddr = '0;
    forever begin
      smp();
      if (rst) begin
        prev_hold = 0;
        prev_ar   = 0;
        continue;
      end
      if (prev_hold) check("inst_hold", {inst_valid, inst, inst_pc, inst_snpc, inst_fault}, {1'b1, prev_bus});
      if (prev_ar) check("ar_hold", {arvalid, araddr}, {1'b1, prev_araddr});
      if (arvalid || rready) check("req_ready_busy", req_ready, 1'b0);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_inst", inst_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("inst", inst, e.inst);
          check("inst_pc", inst_pc, e.pc);
          check("inst_snpc", inst_snpc, e.snpc);
          check("inst_fault", inst_fault, e.fault);
        end
      end
      prev_hold   = inst_valid && !inst_ready;
      prev_bus    = {inst, inst_pc, inst_snpc, inst_fault};
      prev_ar     = arvalid && !arready;
      prev_araddr = araddr;
    end
  end

  // Randomized AXI slave backed by mem_word/mem_resp.
  initial begin : axi_slave
    logic [31:0] a;
    bit          early, hs;
    forever begin
      tick();
      if (!slave_en || rst || !arvalid) continue;
      early = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) tick();
      a = araddr;
      arready = 1'b1;
      if (early) begin
        rvalid = 1'b1; rdata = mem_word(a); rresp = mem_resp(a);
      end
      tick();
      arready = 1'b0;
      if (!early) begin
        repeat ($urandom_range(0, 3)) tick();
        rvalid = 1'b1; rdata = mem_word(a); rresp = mem_resp(a);
      end
      hs = 0;
      for (int i = 0; i < 100 && !hs; i++) begin
        smp();
        hs = rready;
        tick();
      end
      rvalid = 1'b0;
      check("r_handshake", hs, 1'b1);
    end
  end

  initial begin : ready_driver
    forever begin
      tick();
      if (rand_mode) inst_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : time_limit
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    logic [31:0] pc;
    rst = 1'b1; req_valid = 0; req_pc = '0; arready = 0; rvalid = 0;
    rdata = '0; rresp = 2'b00; inst_ready = 0;

    // Reset state
    repeat (2) tick();
    smp();
    check("rst_ctrl", {arvalid, rready, inst_valid, inst_fault, req_ready}, 5'b0);
    check("rst_data", {inst, inst_pc, araddr, inst_snpc}, 128'h0);
    tick(); rst = 1'b0;
    smp(); check("idle_req_ready", req_ready, 1'b1);

    // Zero-wait fetch: inst_valid three cycles after the request
    tick(); req_valid = 1; req_pc = 32'h8000_0000;
    smp(); check("basic_accept", req_ready, 1'b1);
    exp_q.push_back(model(32'h8000_0000, 32'h0010_0093, 2'b00));
    tick(); req_valid = 0; arready = 1;
    smp(); check("basic_arvalid", {arvalid, araddr}, {1'b1, 32'h8000_0000});
    check("basic_no_rready", rready, 1'b0);
    tick(); arready = 0; rvalid = 1; rdata = 32'h0010_0093; rresp = 2'b00;
    smp(); check("basic_rready", {rready, inst_valid}, 2'b10);
    tick(); rvalid = 0; inst_ready = 1;
    smp(); check("basic_lat3", inst_valid, 1'b1);
    tick(); inst_ready = 0;
    smp(); check("basic_drop", inst_valid, 1'b0);

    // AR stall for 5 cycles, then SLVERR response
    tick(); req_valid = 1; req_pc = 32'h8000_0010;
    smp(); exp_q.push_back(model(32'h8000_0010, 32'h1234_5678, 2'b10));
    tick(); req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      smp();
      check("ar_stall", {arvalid, araddr, req_ready}, {1'b1, 32'h8000_0010, 1'b0});
      tick();
    end
    arready = 1;
    smp(); tick(); arready = 0; rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10;
    smp(); check("data_busy", {rready, req_ready}, 2'b10);
    tick(); rvalid = 0; rresp = 2'b00;

    // Decode stall for 4 cycles, then chained request at the top of the address space
    for (int i = 0; i < 4; i++) begin
      smp();
      check("out_stall", {inst_valid, inst, inst_fault}, {1'b1, 32'h1234_5678, 1'b1});
      tick();
    end
    inst_ready = 1; req_valid = 1; req_pc = 32'hFFFF_FFFC;
    smp(); check("chain_accept", req_ready, 1'b1);
    exp_q.push_back(model(32'hFFFF_FFFC, 32'h0000_0513, 2'b00));
    // rvalid raised together with arready must wait for DATA
    tick(); inst_ready = 0; req_valid = 0; arready = 1; rvalid = 1; rdata = 32'h0000_0513;
    smp(); check("chain_addr", {arvalid, araddr, rready, inst_valid}, {1'b1, 32'hFFFF_FFFC, 2'b00});
    tick(); arready = 0;
    smp(); check("early_r_wait", {rready, inst_valid}, 2'b10);
    tick(); rvalid = 0; inst_ready = 1;
    smp(); check("wrap_valid", inst_valid, 1'b1);
    tick(); inst_ready = 0;

    // Misaligned PC faults next cycle without touching the bus
    req_valid = 1; req_pc = 32'h8000_0002;
    smp(); exp_q.push_back(model(32'h8000_0002, 32'h0, 2'b00));
    tick(); req_valid = 0; inst_ready = 1;
    smp(); check("misalign_out", {inst_valid, arvalid}, 2'b10);
    tick(); inst_ready = 0;
    smp(); check("misalign_no_bus", {arvalid, inst_valid}, 2'b00);

`ifdef IFU_TIMEOUT_EN
    // R never answers: fault eight cycles after DATA entry
    tick(); req_valid = 1; req_pc = 32'h8000_0040;
    smp(); exp_q.push_back('{inst: 32'h0000_0013, pc: 32'h8000_0040, snpc: 32'h8000_0044, fault: 1'b1});
    tick(); req_valid = 0; arready = 1;
    smp(); tick(); arready = 0;
    for (int i = 0; i < 8; i++) begin
      smp();
      check("wd_wait", {inst_valid, rready}, 2'b01);
      tick();
    end
    inst_ready = 1;
    smp(); check("wd_expire", {inst_valid, rready}, 2'b10);
    tick(); inst_ready = 0;
`endif

    // Reset mid-DATA with a pending rvalid
    tick(); req_valid = 1; req_pc = 32'h8000_0020;
    smp(); tick(); req_valid = 0; arready = 1;
    smp(); tick(); arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; rst = 1;
    smp();
    check("midrst_ctrl", {arvalid, rready, inst_valid, inst_fault, req_ready}, 5'b0);
    check("midrst_data", {inst, inst_pc, araddr, inst_snpc}, 128'h0);
    tick(); smp(); tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("late_r_ignored", {inst_valid, rready, arvalid, req_ready}, 4'b0001);
      tick();
    end
    rvalid = 0; rdata = '0;

    // Randomized traffic
    rand_mode = 1; slave_en = 1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      case ($urandom_range(0, 9))
        0: begin pc = $urandom(); pc[1:0] = 2'($urandom_range(1, 3)); end
        1: pc = 32'hFFFF_FFFC;
        default: begin pc = $urandom(); pc[1:0] = 2'b00; end
      endcase
      send_req(pc);
    end
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick();
    check("drain", exp_q.size(), 0);
    rand_mode = 0; slave_en = 0; inst_ready = 0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage sitting between the PC register and the decode-stage bus. It accepts a fetch request carrying a PC and issues a single AXI4-Lite read on the AR/R channels. The returned word is registered and presented to decode over a valid/ready handshake, together with its PC, PC+4 and a fault flag. Exactly one transaction is outstanding at any time, which keeps instruction order trivially intact.

## Interface
Parameters:
- ADDR_W, 32, address/PC width
- DATA_W, 32, instruction width (fixed 32 for RV32)
- TIMEOUT_CYCLES, 255, watchdog limit in R-wait cycles (used only with IFU_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted when high together with req_valid
- req_pc  in  ADDR_W  PC to fetch
- araddr  out  ADDR_W  AXI read address
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- rdata  in  DATA_W  AXI read data
- rresp  in  2  AXI read response (0 = OKAY)
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- inst_valid  out  1  instruction valid to decode
- inst_ready  in  1  decode ready
- inst  out  DATA_W  fetched instruction (0x0000_0013 NOP on fault)
- inst_pc  out  ADDR_W  PC of inst
- inst_snpc  out  ADDR_W  inst_pc + 4, wraps modulo 2^ADDR_W
- inst_fault  out  1  access fault, misaligned PC, or timeout

## Operation
- FSM states: IDLE, ADDR, DATA, OUT.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_pc.
  - If req_pc[1:0] != 0: go to OUT with inst_fault = 1 and inst = NOP. No bus access is made.
  - Otherwise: go to ADDR.
- ADDR:
  - arvalid = 1, with araddr equal to the latched PC.
  - On arready, go to DATA.
  - arvalid and araddr stay stable until arready.
- DATA:
  - rready = 1.
  - On rvalid, capture rdata into inst and set inst_fault = (rresp != 0). Go to OUT.
- OUT:
  - inst_valid = 1; outputs stay stable until inst_ready.
  - On inst_ready with req_valid in the same cycle: accept the new request (req_ready = inst_ready in OUT) and go to ADDR, or to OUT with a fault if misaligned.
  - On inst_ready without req_valid: go to IDLE.
- req_ready is 0 in ADDR and DATA.
- An rvalid arriving in the same cycle as the arready handshake is not consumed; rready first rises in DATA.
- Reset at any point: state = IDLE and every output is driven to 0 (arvalid, rready, inst_valid, inst_fault, inst, inst_pc, araddr, inst_snpc). req_ready = 0 while rst is high, and 1 on the first cycle after release.
- A transaction interrupted by reset is abandoned. Any late rvalid after reset is ignored because rready = 0 in IDLE.

## Timing
- Request handshake in cycle 0 gives arvalid = 1 in cycle 1 (registered).
- With zero-wait memory (arready = 1 in cycle 1, rvalid = 1 in cycle 2), inst_valid = 1 in cycle 3. Minimum latency is 3 cycles from request to instruction.
- Misaligned PC: inst_valid = 1 in cycle 1.
- Back-to-back throughput is one instruction per 3 cycles when zero-wait, using the OUT-to-ADDR chaining.
- All outputs are registered; there are no combinational paths from AXI inputs to decode outputs.

## Configuration
- IFU_TIMEOUT_EN defined:
  - A counter runs in DATA, cleared on entry.
  - When it reaches TIMEOUT_CYCLES without rvalid, go to OUT with inst_fault = 1 and inst = NOP, and drop rready.
  - The count is not reset in ADDR; the watchdog covers only R-wait.
- IFU_TIMEOUT_EN undefined: there is no counter, and DATA waits indefinitely. TIMEOUT_CYCLES is ignored.

## Structure
- Shared package npc_pkg holds:
  - ifu_state_t enum (IDLE, ADDR, DATA, OUT)
  - AXI_RESP_OKAY = 2'b00
  - INST_NOP = 32'h0000_0013
- One sub-module, ifu_watchdog (enable, clear, expired), instantiated only under IFU_TIMEOUT_EN.

## Test plan
- Reset is asserted mid-DATA with rvalid pending. Required: all outputs 0 during reset, IDLE after release, and the late rvalid/rdata 0xDEADBEEF is ignored with no inst_valid.
- Request pc = 0x8000_0000, arready = 1, rvalid = 1 next cycle with rdata = 0x0010_0093 and rresp = 0. Required: inst_valid in cycle 3, inst = 0x0010_0093, inst_pc = 0x8000_0000, inst_snpc = 0x8000_0004, inst_fault = 0.
- Hold arready = 0 for 5 cycles. Required: arvalid and araddr stable for all 5 cycles, and req_ready = 0 throughout.
- Set rresp = 2 with rdata = 0x1234_5678. Required: inst_fault = 1, inst = 0x1234_5678.
- Request pc = 0x8000_0002. Required: no arvalid, inst_valid next cycle, inst_fault = 1, inst = 0x0000_0013.
- Hold inst_ready = 0 for 4 cycles, then drive inst_ready = 1 with req_valid (pc = 0xFFFF_FFFC). Required: outputs held for the 4 cycles; the new request is accepted in the same cycle as the handshake; inst_snpc = 0x0000_0000. With IFU_TIMEOUT_EN and TIMEOUT_CYCLES = 8 and rvalid never asserted: inst_fault = 1 eight cycles after DATA entry.
